// File: rtl/ajc_sr_seq_ctrl_v_pkg.sv
// ajc_sr_seq_ctrl_v_pkg
//   Shared definitions for the shift/rotate sequencer and its 8-bit SR unit:
//   FSM state encoding, function-select codes, the largest per-pass shift and
//   a helper that builds the {C,N,V,Z} flag nibble from a pass result.
package ajc_sr_seq_ctrl_v_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] FS_SHRA  = 2'd0;
    localparam logic [1:0] FS_SHLL  = 2'd1;
    localparam logic [1:0] FS_RRC   = 2'd2;
    localparam logic [1:0] FS_PASSY = 2'd3;

    // The SR unit can move at most this many places in one pass.
    localparam logic [1:0] K_MAX = 2'd3;

    // {C,N,V,Z}: V is never produced by shifts/rotates.
    function automatic logic [3:0] make_cnvz(input logic c, input logic [7:0] res);
        return {c, res[7], 1'b0, (res == 8'h00)};
    endfunction

endpackage

// File: rtl/ajc_sr_seq_ctrl_v_sr_unit.sv
// ajc_8bit_sr_unit_v
//   Combinational 8-bit shift/rotate unit, 0..3 places per evaluation.
//   Ports:
//     Func_Sel  in  2  0=SHRA 1=SHLL 2=RRC 3=PASS_Y
//     Operand_X in  8  value to shift/rotate
//     Operand_Y in  8  pass-through value
//     Const_K   in  2  places to move this pass
//     Cin       in  1  carry into the 9-bit RRC ring {C,X}
//     SR_Result out 8  shifted/rotated/passed value
//     Cout      out 1  ring carry after RRC; 0 for all other functions
module ajc_8bit_sr_unit_v
    import ajc_sr_seq_ctrl_v_pkg::*;
(
    input  logic [1:0] Func_Sel,
    input  logic [7:0] Operand_X,
    input  logic [7:0] Operand_Y,
    input  logic [1:0] Const_K,
    input  logic       Cin,
    output logic [7:0] SR_Result,
    output logic       Cout
);

    logic [8:0] ring_s;
    logic [8:0] rot_s;

    // Function select; RRC rotates the 9-bit ring by shifting a doubled copy
    // and keeping the low nine bits.
    always_comb begin
        SR_Result = Operand_X;
        Cout      = 1'b0;
        ring_s    = {Cin, Operand_X};
        rot_s     = 9'({ring_s, ring_s} >> Const_K);
        case (Func_Sel)
            FS_SHRA: begin
                SR_Result = $signed(Operand_X) >>> Const_K;
                Cout      = 1'b0;
            end
            FS_SHLL: begin
                SR_Result = Operand_X << Const_K;
                Cout      = 1'b0;
            end
            FS_RRC: begin
                SR_Result = rot_s[7:0];
                Cout      = rot_s[8];
            end
            FS_PASSY: begin
                SR_Result = Operand_Y;
                Cout      = 1'b0;
            end
            default: begin
                SR_Result = Operand_X;
                Cout      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ajc_sr_seq_ctrl_v.sv
// ajc_sr_seq_ctrl_v
//   Multi-cycle sequencer around the 3-place SR unit. One accepted operation
//   of up to 2^AMT_W-1 places is split into passes of at most 3 places, the
//   RRC carry is chained between passes, and the final value plus flags are
//   returned with a one-cycle Done pulse.
//   Parameter: AMT_W (>= 2) width of Shift_Amt.
//   Ports:
//     Clock     in  1      rising-edge clock
//     Reset     in  1      asynchronous active-high reset
//     Start     in  1      request, taken only while Ready=1
//     Func_Sel  in  2      0=SHRA 1=SHLL 2=RRC 3=PASS_Y
//     Operand_X in  8      value to shift/rotate
//     Operand_Y in  8      pass-through value
//     Shift_Amt in  AMT_W  total places
//     Cin       in  1      RRC carry-in
//     Ready     out 1      high only in IDLE
//     Done      out 1      one-cycle pulse, Result/CNVZ valid
//     Result    out 8      final value, held until replaced or reset
//     CNVZ      out 4      {C,N,V,Z} of the final pass
module ajc_sr_seq_ctrl_v
    import ajc_sr_seq_ctrl_v_pkg::*;
#(
    parameter int AMT_W = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Func_Sel,
    input  logic [7:0]       Operand_X,
    input  logic [7:0]       Operand_Y,
    input  logic [AMT_W-1:0] Shift_Amt,
    input  logic             Cin,
    output logic             Ready,
    output logic             Done,
    output logic [7:0]       Result,
    output logic [3:0]       CNVZ
);

    state_t           state_r;
    logic [1:0]       func_r;
    logic [7:0]       work_r;
    logic [7:0]       y_r;
    logic [AMT_W-1:0] rem_r;
    logic             carry_r;
    logic             ready_r;
    logic             done_r;
    logic [7:0]       result_r;
    logic [3:0]       cnvz_r;

    logic [1:0]       k_s;
    logic [AMT_W-1:0] rem_next_s;
    logic             last_pass_s;
    logic [7:0]       sr_result_s;
    logic             sr_cout_s;

    // Per-pass size: min(rem,3); the operation ends when nothing remains or
    // the function is PASS_Y, which always completes in one pass.
    always_comb begin
        if (rem_r >= AMT_W'(3)) begin
            k_s = K_MAX;
        end else begin
            k_s = rem_r[1:0];
        end
        rem_next_s  = rem_r - AMT_W'(k_s);
        last_pass_s = (rem_next_s == {AMT_W{1'b0}}) || (func_r == FS_PASSY);
    end

    ajc_8bit_sr_unit_v u_sr (
        .Func_Sel  (func_r),
        .Operand_X (work_r),
        .Operand_Y (y_r),
        .Const_K   (k_s),
        .Cin       (carry_r),
        .SR_Result (sr_result_s),
        .Cout      (sr_cout_s)
    );

    // Sequencer FSM with registered Ready/Done/Result/CNVZ.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            func_r   <= FS_SHRA;
            work_r   <= 8'h00;
            y_r      <= 8'h00;
            rem_r    <= {AMT_W{1'b0}};
            carry_r  <= 1'b0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            result_r <= 8'h00;
            cnvz_r   <= 4'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (Start) begin
                        func_r  <= Func_Sel;
                        work_r  <= Operand_X;
                        y_r     <= Operand_Y;
                        rem_r   <= Shift_Amt;
                        carry_r <= Cin;
                        ready_r <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // work/carry/rem chain into the next pass; they are
                    // deliberately left as-is once the operation finishes.
                    work_r  <= sr_result_s;
                    carry_r <= sr_cout_s;
                    rem_r   <= rem_next_s;
                    ready_r <= 1'b0;
                    if (last_pass_s) begin
                        result_r <= sr_result_s;
                        cnvz_r   <= make_cnvz(sr_cout_s, sr_result_s);
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        done_r   <= 1'b0;
                        state_r  <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Ready  = ready_r;
    assign Done   = done_r;
    assign Result = result_r;
    assign CNVZ   = cnvz_r;

endmodule

// File: tb/tb_ajc_sr_seq_ctrl_v.sv
// Scoreboard bench for ajc_sr_seq_ctrl_v: expected {Result,CNVZ} are queued
// when an operation is issued; monitors pop and compare on every Done pulse.
// Two instances: AMT_W=3 (default) and AMT_W=4 (for amounts >= 8).
module tb_ajc_sr_seq_ctrl_v;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       start3;
    logic       start4;
    logic [1:0] func;
    logic [7:0] opx;
    logic [7:0] opy;
    logic [3:0] amt;
    logic       cin;

    logic       ready3, done3, ready4, done4;
    logic [7:0] res3, res4;
    logic [3:0] cnvz3, cnvz4;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] cnvz;
    } exp_t;

    exp_t q3[$];
    exp_t q4[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 Clock = ~Clock;

    ajc_sr_seq_ctrl_v #(.AMT_W(3)) dut3 (
        .Clock(Clock), .Reset(Reset), .Start(start3), .Func_Sel(func),
        .Operand_X(opx), .Operand_Y(opy), .Shift_Amt(amt[2:0]), .Cin(cin),
        .Ready(ready3), .Done(done3), .Result(res3), .CNVZ(cnvz3)
    );

    ajc_sr_seq_ctrl_v #(.AMT_W(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .Start(start4), .Func_Sel(func),
        .Operand_X(opx), .Operand_Y(opy), .Shift_Amt(amt), .Cin(cin),
        .Ready(ready4), .Done(done4), .Result(res4), .CNVZ(cnvz4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor for the AMT_W=3 instance.
    always @(negedge Clock) begin
        if (Reset === 1'b0 && done3 === 1'b1) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut3_unexpected_done actual=%0h required=none", res3);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("dut3_result", 32'(res3), 32'(e.res));
                check("dut3_cnvz", 32'(cnvz3), 32'(e.cnvz));
            end
        end
    end

    // Monitor for the AMT_W=4 instance.
    always @(negedge Clock) begin
        if (Reset === 1'b0 && done4 === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut4_unexpected_done actual=%0h required=none", res4);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("dut4_result", 32'(res4), 32'(e.res));
                check("dut4_cnvz", 32'(cnvz4), 32'(e.cnvz));
            end
        end
    end

    task automatic wait_ready(input bit sel4, input string name);
        int cnt = 0;
        while (!(sel4 ? ready4 : ready3) && cnt < 50) begin
            @(negedge Clock);
            cnt++;
        end
        check({name, "_ready"}, 32'(sel4 ? ready4 : ready3), 32'd1);
    endtask

    // Issue one op, scramble operands after acceptance, check pass latency.
    task automatic run_op(input bit sel4, input logic [1:0] f, input logic [7:0] x,
                          input logic [7:0] y, input logic [3:0] a, input logic c,
                          input logic [7:0] eres, input logic [3:0] ecnvz,
                          input int n, input string name);
        int lat = 0;
        wait_ready(sel4, name);
        func = f; opx = x; opy = y; amt = a; cin = c;
        if (sel4) begin
            q4.push_back('{res: eres, cnvz: ecnvz});
            start4 = 1'b1;
        end else begin
            q3.push_back('{res: eres, cnvz: ecnvz});
            start3 = 1'b1;
        end
        @(posedge Clock);
        @(negedge Clock);
        start3 = 1'b0;
        start4 = 1'b0;
        func = ~f; opx = ~x; opy = ~y; amt = ~a; cin = ~c;
        while (!(sel4 ? done4 : done3) && lat < 40) begin
            @(negedge Clock);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int pulses;
        int last_t;
        Reset = 1'b1; start3 = 1'b0; start4 = 1'b0;
        func = 2'd0; opx = 8'h00; opy = 8'h00; amt = 4'd0; cin = 1'b0;
        repeat (2) @(negedge Clock);
        check("reset_ready", 32'(ready3), 32'd1);
        check("reset_done", 32'(done3), 32'd0);
        check("reset_result", 32'(res3), 32'd0);
        check("reset_cnvz", 32'(cnvz3), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);

        //      sel  func  X      Y      amt    cin   res    cnvz     n
        run_op(1'b0, 2'd1, 8'h01, 8'h00, 4'd7, 1'b0, 8'h80, 4'b0100, 3, "shll_7");
        run_op(1'b0, 2'd0, 8'h80, 8'h00, 4'd5, 1'b0, 8'hFC, 4'b0100, 2, "shra_5");
        run_op(1'b0, 2'd2, 8'h01, 8'h00, 4'd1, 1'b0, 8'h00, 4'b1001, 1, "rrc_1");
        run_op(1'b0, 2'd3, 8'h55, 8'h00, 4'd7, 1'b1, 8'h00, 4'b0001, 1, "passy");
        run_op(1'b0, 2'd1, 8'h3C, 8'h00, 4'd0, 1'b1, 8'h3C, 4'b0000, 1, "shll_0");
        run_op(1'b0, 2'd2, 8'h81, 8'h00, 4'd0, 1'b1, 8'h81, 4'b1100, 1, "rrc_0");
        run_op(1'b0, 2'd0, 8'h7F, 8'h00, 4'd7, 1'b0, 8'h00, 4'b0001, 3, "shra_7");
        run_op(1'b0, 2'd1, 8'hFF, 8'h00, 4'd3, 1'b0, 8'hF8, 4'b0100, 1, "shll_3");
        run_op(1'b0, 2'd2, 8'h80, 8'h00, 4'd4, 1'b1, 8'h18, 4'b0000, 2, "rrc_4");
        run_op(1'b1, 2'd2, 8'hA5, 8'h00, 4'd9, 1'b1, 8'hA5, 4'b1100, 3, "rrc_9_w4");
        run_op(1'b1, 2'd1, 8'h01, 8'h00, 4'd15, 1'b0, 8'h00, 4'b0001, 5, "shll_15_w4");

        // Start pulsed while busy with different operands must be ignored.
        wait_ready(1'b0, "busy_start");
        func = 2'd1; opx = 8'h01; amt = 4'd7; cin = 1'b0;
        q3.push_back('{res: 8'h80, cnvz: 4'b0100});
        start3 = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        start3 = 1'b0;
        @(negedge Clock);
        func = 2'd0; opx = 8'hFF; amt = 4'd1; start3 = 1'b1;
        @(negedge Clock);
        start3 = 1'b0;
        cnt = 0;
        while (!done3 && cnt < 40) begin
            @(negedge Clock);
            cnt++;
        end
        check("busy_start_done_seen", 32'(done3), 32'd1);
        repeat (6) @(negedge Clock);
        check("busy_start_no_extra", 32'(q3.size()), 32'd0);

        // Reset mid-RUN aborts immediately without a later Done.
        wait_ready(1'b0, "abort");
        func = 2'd0; opx = 8'h80; amt = 4'd7; start3 = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        start3 = 1'b0;
        @(negedge Clock);
        check("abort_busy", 32'(ready3), 32'd0);
        Reset = 1'b1;
        #1;
        check("abort_ready", 32'(ready3), 32'd1);
        check("abort_done", 32'(done3), 32'd0);
        check("abort_result", 32'(res3), 32'd0);
        check("abort_cnvz", 32'(cnvz3), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (8) @(negedge Clock);

        // Start held high: one accept per op, Done every n+2 = 4 cycles.
        wait_ready(1'b0, "held");
        func = 2'd0; opx = 8'h80; amt = 4'd5; cin = 1'b0;
        for (int i = 0; i < 3; i++) q3.push_back('{res: 8'hFC, cnvz: 4'b0100});
        start3 = 1'b1;
        pulses = 0;
        last_t = 0;
        for (int t = 1; t <= 40 && pulses < 3; t++) begin
            @(negedge Clock);
            if (done3) begin
                if (pulses > 0) check("held_spacing", 32'(t - last_t), 32'd4);
                last_t = t;
                pulses++;
            end
        end
        start3 = 1'b0;
        check("held_pulses", 32'(pulses), 32'd3);
        repeat (8) @(negedge Clock);

        check("q3_empty", 32'(q3.size()), 32'd0);
        check("q4_empty", 32'(q4.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
